bus_condition_gen: RTL and testbench

Bus condition generator: drives START, Repeated START and STOP on the open-drain SCL/SDA outputs with programmable timing, the transmit-side counterpart of the bus monitor's condition detection. It sits between the controller FSM, which issues one condition per request/ack handshake, and the pad drivers. Each condition executes as a fixed sequence of timed phases. All timing values are in `clk_i` cycles.

---
 rtl/i3c_pkg.sv | 72 +++++++
 rtl/phase_timer.sv | 40 ++++
 rtl/bus_condition_gen.sv | 165 ++++++++++++++++
 tb/tb_bus_condition_gen.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i3c_pkg.sv
// Shared types and small helpers for the bus condition generator.
package i3c_pkg;

    typedef enum logic [1:0] {
        GEN_START  = 2'd0,
        GEN_RSTART = 2'd1,
        GEN_STOP   = 2'd2,
        GEN_RSVD   = 2'd3
    } gen_cmd_t;

    // ST_ERR is the single ack/err cycle of a reserved command
    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_S_HD  = 4'd1,
        ST_S_LOW = 4'd2,
        ST_R_SDA = 4'd3,
        ST_R_SU  = 4'd4,
        ST_P_SDA = 4'd5,
        ST_P_SU  = 4'd6,
        ST_P_REL = 4'd7,
        ST_ERR   = 4'd8
    } gen_state_t;

    // Open-drain line levels: 1 = released, 0 = driven low
    typedef struct packed {
        logic scl;
        logic sda;
    } line_t;

    // Fixed SCL/SDA levels driven during each timed phase
    function automatic line_t phase_lines(gen_state_t st);
        line_t l;
        l = '{scl: 1'b1, sda: 1'b1};
        case (st)
            ST_S_HD:  l = '{scl: 1'b1, sda: 1'b0};
            ST_S_LOW: l = '{scl: 1'b0, sda: 1'b0};
            ST_R_SDA: l = '{scl: 1'b0, sda: 1'b1};
            ST_R_SU:  l = '{scl: 1'b1, sda: 1'b1};
            ST_P_SDA: l = '{scl: 1'b0, sda: 1'b0};
            ST_P_SU:  l = '{scl: 1'b1, sda: 1'b0};
            ST_P_REL: l = '{scl: 1'b1, sda: 1'b1};
            default:  l = '{scl: 1'b1, sda: 1'b1};
        endcase
        return l;
    endfunction

    // Phase sequencing; ST_IDLE after the final phase of a condition
    function automatic gen_state_t next_phase(gen_state_t st);
        gen_state_t n;
        n = ST_IDLE;
        case (st)
            ST_R_SDA: n = ST_R_SU;
            ST_R_SU:  n = ST_S_HD;
            ST_S_HD:  n = ST_S_LOW;
            ST_P_SDA: n = ST_P_SU;
            ST_P_SU:  n = ST_P_REL;
            default:  n = ST_IDLE;
        endcase
        return n;
    endfunction

    // Final phase of a condition, where ack is issued
    function automatic logic is_last_phase(gen_state_t st);
        return (st == ST_S_LOW) || (st == ST_P_REL);
    endfunction

    // Phases that release SCL and may be stretched by a target
    function automatic logic scl_high_phase(gen_state_t st);
        return (st == ST_R_SU) || (st == ST_S_HD) || (st == ST_P_SU) || (st == ST_P_REL);
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter timing one generator phase; done marks the last cycle.
module phase_timer #(
    parameter int unsigned Width = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    input  logic             en,
    output logic             done,
    output logic             done_next_c
);

    logic [Width-1:0] cnt_q;
    logic [Width-1:0] cnt_d;

    // Next count: load wins, otherwise decrement without wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    assign done_next_c = (cnt_d == '0);

    // Count register with a registered zero flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            done  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            done  <= done_next_c;
        end
    end

endmodule

// File: rtl/bus_condition_gen.sv
// Generates START / Repeated START / STOP on open-drain SCL/SDA as timed phases.
// Optional build macro I3C_GEN_CLOCK_STRETCH_EN: SCL-high phases wait for scl_i=1.
module bus_condition_gen
    import i3c_pkg::*;
#(
    parameter int unsigned CntW = 20
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            enable_i,
    input  logic            req_i,
    input  logic [1:0]      cmd_i,
    input  logic [CntW-1:0] t_r_i,
    input  logic [CntW-1:0] t_f_i,
    input  logic [CntW-1:0] t_su_sta_i,
    input  logic [CntW-1:0] t_hd_sta_i,
    input  logic [CntW-1:0] t_su_sto_i,
    input  logic            scl_i,
    output logic            scl_o,
    output logic            sda_o,
    output logic            busy_o,
    output logic            ack_o,
    output logic            err_o
);

    localparam int unsigned DurW = CntW + 1;

    gen_state_t      state_q;
    gen_state_t      state_d;
    line_t           lines_q;
    line_t           lines_d;
    logic            rel_pend_q;
    logic            rel_pend_d;
    logic            busy_d;
    logic            ack_d;
    logic            err_d;
    logic            abort;
    logic            stretch_ok;
    logic            tmr_load;
    logic            tmr_en;
    logic            tmr_done;
    logic            tmr_done_next;
    logic [DurW-1:0] dur;
    logic [DurW-1:0] load_val;

`ifdef I3C_GEN_CLOCK_STRETCH_EN
    // SCL-high phases only count once the bus really shows SCL high
    assign stretch_ok = !scl_high_phase(state_q) || scl_i;
`else
    logic unused_scl;
    assign unused_scl = scl_i;
    assign stretch_ok = 1'b1;
`endif

    // Duration of the phase being entered; D=0 still costs one cycle
    always_comb begin
        dur = '0;
        case (state_d)
            ST_S_HD:            dur = DurW'(t_f_i) + DurW'(t_hd_sta_i);
            ST_S_LOW, ST_P_SDA: dur = DurW'(t_f_i);
            ST_R_SDA, ST_P_REL: dur = DurW'(t_r_i);
            ST_R_SU:            dur = DurW'(t_r_i) + DurW'(t_su_sta_i);
            ST_P_SU:            dur = DurW'(t_r_i) + DurW'(t_su_sto_i);
            default:            dur = '0;
        endcase
        load_val = (dur == '0) ? '0 : (dur - DurW'(1));
    end

    // Next-state logic: request decode, phase sequencing and abort
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        abort    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_i && req_i) begin
                    tmr_load = 1'b1;
                    case (gen_cmd_t'(cmd_i))
                        GEN_START:  state_d = ST_S_HD;
                        GEN_RSTART: state_d = ST_R_SDA;
                        GEN_STOP:   state_d = ST_P_SDA;
                        default: begin
                            state_d  = ST_ERR;
                            tmr_load = 1'b0;
                        end
                    endcase
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                    abort   = 1'b1;
                end else if (stretch_ok) begin
                    if (tmr_done) begin
                        state_d  = next_phase(state_q);
                        tmr_load = (state_d != ST_IDLE);
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
            end
        endcase
    end

    // Output values for the next cycle, derived from the next state
    always_comb begin
        lines_d    = lines_q;
        rel_pend_d = 1'b0;
        if (abort) begin
            // release SDA first while SCL holds, SCL follows a cycle later
            lines_d.sda = 1'b1;
            rel_pend_d  = 1'b1;
        end else if ((state_d == ST_IDLE) || (state_d == ST_ERR)) begin
            if (rel_pend_q) begin
                lines_d.scl = 1'b1;
            end
        end else begin
            lines_d = phase_lines(state_d);
        end
        busy_d = (state_d != ST_IDLE);
        err_d  = (state_d == ST_ERR);
        // a stalled last phase already sitting at zero must not re-ack
        ack_d  = err_d || (is_last_phase(state_d) && tmr_done_next &&
                           !((state_d == state_q) && tmr_done));
    end

    // State and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            lines_q    <= '{scl: 1'b1, sda: 1'b1};
            rel_pend_q <= 1'b0;
            busy_o     <= 1'b0;
            ack_o      <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lines_q    <= lines_d;
            rel_pend_q <= rel_pend_d;
            busy_o     <= busy_d;
            ack_o      <= ack_d;
            err_o      <= err_d;
        end
    end

    assign scl_o = lines_q.scl;
    assign sda_o = lines_q.sda;

    phase_timer #(
        .Width(DurW)
    ) u_phase_timer (
        .clk        (clk_i),
        .rst_n      (rst_ni),
        .load       (tmr_load),
        .load_val   (load_val),
        .en         (tmr_en),
        .done       (tmr_done),
        .done_next_c(tmr_done_next)
    );

endmodule

// File: tb/tb_bus_condition_gen.sv
// Directed bench for bus_condition_gen: START/RSTART/STOP timing, zero timings,
// reserved command, abort, stretch (expectation follows I3C_GEN_CLOCK_STRETCH_EN), reset.
module tb_bus_condition_gen;

    localparam int unsigned CntW = 20;

    logic            clk;
    logic            rst_n;
    logic            enable;
    logic            req;
    logic [1:0]      cmd;
    logic [CntW-1:0] t_r;
    logic [CntW-1:0] t_f;
    logic [CntW-1:0] t_su_sta;
    logic [CntW-1:0] t_hd_sta;
    logic [CntW-1:0] t_su_sto;
    logic            scl_in;
    logic            scl;
    logic            sda;
    logic            busy;
    logic            ack;
    logic            err;

    int checks = 0;
    int errors = 0;

    logic tr_scl  [0:127];
    logic tr_sda  [0:127];
    logic tr_busy [0:127];
    logic tr_err  [0:127];
    int   ack_at;
    int   n_runs;
    int   run_len [0:15];

    int   start_cnt  = 0;
    int   rstart_cnt = 0;
    int   stop_cnt   = 0;
    logic bus_act    = 1'b0;
    logic pscl       = 1'b1;
    logic psda       = 1'b1;

    bus_condition_gen #(.CntW(CntW)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .enable_i  (enable),
        .req_i     (req),
        .cmd_i     (cmd),
        .t_r_i     (t_r),
        .t_f_i     (t_f),
        .t_su_sta_i(t_su_sta),
        .t_hd_sta_i(t_hd_sta),
        .t_su_sto_i(t_su_sto),
        .scl_i     (scl_in),
        .scl_o     (scl),
        .sda_o     (sda),
        .busy_o    (busy),
        .ack_o     (ack),
        .err_o     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Minimal bus monitor: SDA edges while SCL stays high
    always @(negedge clk) begin
        if (!rst_n) begin
            pscl    <= 1'b1;
            psda    <= 1'b1;
            bus_act <= 1'b0;
        end else begin
            if (pscl && scl && psda && !sda) begin
                if (bus_act) rstart_cnt++;
                else         start_cnt++;
                bus_act <= 1'b1;
            end
            if (pscl && scl && !psda && sda) begin
                stop_cnt++;
                bus_act <= 1'b0;
            end
            pscl <= scl;
            psda <= sda;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request (cycle 0) and trace until ack; scl_in low on cycles [st_from, st_from+st_len)
    task automatic run_cond(input string tag, input logic [1:0] c, input int st_from, input int st_len);
        cmd    = c;
        req    = 1'b1;
        ack_at = 0;
        for (int i = 0; i < 100; i++) begin
            scl_in = (i >= st_from && i < st_from + st_len) ? 1'b0 : 1'b1;
            tick();
            req = 1'b0;
            tr_scl[i+1]  = scl;
            tr_sda[i+1]  = sda;
            tr_busy[i+1] = busy;
            tr_err[i+1]  = err;
            if (ack === 1'b1) begin
                ack_at = i + 1;
                break;
            end
        end
        scl_in = 1'b1;
        check_b({tag, "_ack_seen"}, 1'(ack_at != 0), 1'b1);
    endtask

    // Split the recorded trace 1..n into runs of constant (scl,sda)
    task automatic count_runs(input int n);
        n_runs = 0;
        for (int i = 1; i <= n; i++) begin
            if (i == 1 || tr_scl[i] !== tr_scl[i-1] || tr_sda[i] !== tr_sda[i-1]) begin
                if (n_runs < 16) run_len[n_runs] = 1;
                n_runs++;
            end else if (n_runs <= 16) begin
                run_len[n_runs-1]++;
            end
        end
    endtask

    task automatic set_timing(input int r, input int f, input int su_sta, input int hd_sta, input int su_sto);
        t_r      = CntW'(r);
        t_f      = CntW'(f);
        t_su_sta = CntW'(su_sta);
        t_hd_sta = CntW'(hd_sta);
        t_su_sto = CntW'(su_sto);
    endtask

    task automatic check_idle_after(input string tag);
        tick();
        check_b({tag, "_ack_drop"}, ack, 1'b0);
        check_b({tag, "_busy_drop"}, busy, 1'b0);
    endtask

    initial begin
        int first_low;
        int exp_stretch;

        rst_n  = 1'b0;
        enable = 1'b0;
        req    = 1'b0;
        cmd    = 2'd0;
        scl_in = 1'b1;
        set_timing(3, 2, 5, 4, 6);
        #12;

        // reset values
        check_b("rst_scl", scl, 1'b1);
        check_b("rst_sda", sda, 1'b1);
        check_b("rst_busy", busy, 1'b0);
        check_b("rst_ack", ack, 1'b0);
        check_b("rst_err", err, 1'b0);
        rst_n  = 1'b1;
        enable = 1'b1;
        tick();
        tick();

        // START: SDA falls at +1, SCL at +7, ack at +8
        run_cond("start", 2'd0, -1, 0);
        check_b("start_sda_p1", tr_sda[1], 1'b0);
        check_b("start_scl_p1", tr_scl[1], 1'b1);
        check_b("start_busy_p1", tr_busy[1], 1'b1);
        first_low = 0;
        for (int i = ack_at; i >= 1; i--) if (tr_scl[i] === 1'b0) first_low = i;
        check_i("start_scl_fall", first_low, 7);
        check_i("start_ack_at", ack_at, 8);
        check_b("start_busy_ack", tr_busy[ack_at], 1'b1);
        check_idle_after("start");
        check_b("start_end_scl", scl, 1'b0);
        check_b("start_end_sda", sda, 1'b0);
        check_i("start_det", start_cnt, 1);

        // RSTART: phases 3/8/6/2
        run_cond("rs", 2'd1, -1, 0);
        check_i("rs_ack_at", ack_at, 19);
        count_runs(ack_at);
        check_i("rs_runs", n_runs, 4);
        check_i("rs_ph0", run_len[0], 3);
        check_i("rs_ph1", run_len[1], 8);
        check_i("rs_ph2", run_len[2], 6);
        check_i("rs_ph3", run_len[3], 2);
        check_idle_after("rs");
        check_i("rstart_det", rstart_cnt, 1);

        // STOP: phases 2/9/3, bus idle afterwards
        run_cond("stop", 2'd2, -1, 0);
        check_i("stop_ack_at", ack_at, 14);
        count_runs(ack_at);
        check_i("stop_runs", n_runs, 3);
        check_i("stop_ph0", run_len[0], 2);
        check_i("stop_ph1", run_len[1], 9);
        check_i("stop_ph2", run_len[2], 3);
        check_idle_after("stop");
        check_b("stop_end_scl", scl, 1'b1);
        check_b("stop_end_sda", sda, 1'b1);
        check_i("stop_det", stop_cnt, 1);

        // zero timings: every phase lasts one cycle
        set_timing(0, 0, 0, 0, 0);
        run_cond("z_start", 2'd0, -1, 0);
        check_i("z_start_ack_at", ack_at, 2);
        tick();
        run_cond("z_rs", 2'd1, -1, 0);
        check_i("z_rs_ack_at", ack_at, 4);
        count_runs(ack_at);
        check_i("z_rs_runs", n_runs, 4);
        tick();
        run_cond("z_stop", 2'd2, -1, 0);
        check_i("z_stop_ack_at", ack_at, 3);
        count_runs(ack_at);
        check_i("z_stop_runs", n_runs, 3);
        check_idle_after("z_stop");

        // reserved command: ack+err at +1, lines unchanged
        set_timing(3, 2, 5, 4, 6);
        run_cond("rsvd", 2'd3, -1, 0);
        check_i("rsvd_ack_at", ack_at, 1);
        check_b("rsvd_err", tr_err[1], 1'b1);
        check_b("rsvd_scl", tr_scl[1], 1'b1);
        check_b("rsvd_sda", tr_sda[1], 1'b1);
        tick();
        check_b("rsvd_err_drop", err, 1'b0);
        check_b("rsvd_ack_drop", ack, 1'b0);

        // abort mid P_SU
        run_cond("ab1_start", 2'd0, -1, 0);
        tick();
        cmd = 2'd2;
        req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        tick();
        check_b("ab1_psu_scl", scl, 1'b1);
        check_b("ab1_psu_sda", sda, 1'b0);
        enable = 1'b0;
        tick();
        check_b("ab1_sda_rel", sda, 1'b1);
        check_b("ab1_scl", scl, 1'b1);
        check_b("ab1_busy", busy, 1'b0);
        check_b("ab1_ack", ack, 1'b0);
        enable = 1'b1;
        tick();
        check_b("ab1_ack2", ack, 1'b0);
        check_b("ab1_scl2", scl, 1'b1);

        // abort in P_SDA: SDA released first, SCL one cycle later
        run_cond("ab2_start", 2'd0, -1, 0);
        tick();
        cmd = 2'd2;
        req = 1'b1;
        tick();
        req = 1'b0;
        check_b("ab2_psda_scl", scl, 1'b0);
        enable = 1'b0;
        tick();
        check_b("ab2_sda_rel", sda, 1'b1);
        check_b("ab2_scl_hold", scl, 1'b0);
        check_b("ab2_busy", busy, 1'b0);
        check_b("ab2_ack", ack, 1'b0);
        enable = 1'b1;
        tick();
        check_b("ab2_scl_rel", scl, 1'b1);
        check_b("ab2_sda2", sda, 1'b1);
        check_b("ab2_ack2", ack, 1'b0);

        // scl_i held low for 10 cycles inside R_SU
`ifdef I3C_GEN_CLOCK_STRETCH_EN
        exp_stretch = 29;
`else
        exp_stretch = 19;
`endif
        run_cond("st_start", 2'd0, -1, 0);
        tick();
        run_cond("st_rs", 2'd1, 5, 10);
        check_i("stretch_ack_at", ack_at, exp_stretch);
        check_idle_after("st_rs");

        // reset mid-operation returns outputs to reset values at once
        cmd = 2'd2;
        req = 1'b1;
        tick();
        req = 1'b0;
        check_b("mr_busy_pre", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_b("mr_scl", scl, 1'b1);
        check_b("mr_sda", sda, 1'b1);
        check_b("mr_busy", busy, 1'b0);
        check_b("mr_ack", ack, 1'b0);
        rst_n = 1'b1;
        tick();
        check_b("mr_idle_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
